univ_shift_reg: RTL
===================

Name: univ_shift_reg

Overview:
- Parametrised successor to the team's fixed 4-bit PIPO register.
- Adds WIDTH generalisation, a mode-selected universal datapath (hold, parallel load, shift left/right, rotate left/right), serial in/out at both ends, and an autonomous burst serialiser (FSM, bit counter, busy/done).
- Sits between parallel producers and serial links or bit-level consumers in the datapath.

Parameters:
- WIDTH, 4, register width in bits (≥2).
- RESET_VAL, {WIDTH{1'b0}}, value loaded into po on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  clock enable for all register/counter updates.
- mode  input  3  operation select (see Behaviour).
- pi  input  WIDTH  parallel data in.
- sin_l  input  1  serial in at MSB (shift right / burst fill).
- sin_r  input  1  serial in at LSB (shift left).
- start  input  1  burst request, single-cycle pulse.
- po  output  WIDTH  register contents.
- sout_l  output  1  equals po[WIDTH-1], combinational.
- sout_r  output  1  equals po[0], combinational.
- busy  output  1  high while a burst is in progress.
- done  output  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately): po=RESET_VAL, busy=0, done=0, FSM=IDLE, counter=0. Reset mid-burst aborts the burst and produces no done pulse.
- All other updates occur on the rising clk edge while rst=1.
- Mode decode (IDLE only, en=1):
  - 000: hold.
  - 001: po<=pi.
  - 010: shift left, po<={po[WIDTH-2:0],sin_r}.
  - 011: shift right, po<={sin_l,po[WIDTH-1:1]}.
  - 100: rotate left.
  - 101: rotate right.
  - 110, 111: reserved, behave as hold.
- en=0: po, FSM and counter hold. done still deasserts on the following edge.
- FSM states:
  - IDLE: start=1 and en=1 → po<=pi, counter<=WIDTH, busy<=1, go BURST. start has priority over mode on that edge.
  - BURST: each edge with en=1 → shift right (sin_l into MSB), counter<=counter-1. On the edge where counter goes 1→0: busy<=0, done<=1, go IDLE.
- done is cleared on every other edge. done and busy are never high together.
- Burst timing: after the start edge, sout_r presents pi[0], pi[1], … pi[WIDTH-1] on WIDTH consecutive enabled cycles, LSB first.
  - Latency from start to done high is WIDTH+1 edges when en is held high.
  - en=0 stalls the burst with no bit lost.
- In BURST, mode and start are ignored; a start while busy is dropped, not queued.
- A start on the same edge that done is set is accepted only on a later edge, because the FSM evaluates start in IDLE only.
- Counter width: $clog2(WIDTH+1) bits. No wrap: the counter never decrements below 0.

Test Plan:
- Reset/load: hold rst=0 → po=0, busy=0, done=0 without a clock edge; release, mode=001, pi=4'b0101 → po=4'b0101 after one edge; mode=000 → po stays 4'b0101.
- Shift: from 4'b0101, mode=010 with sin_r=1 → 4'b1011. From 4'b0101, mode=011 with sin_l=0 → 4'b0010. Check sout_l/sout_r track po[3]/po[0].
- Rotate: mode=100 on 4'b0101 → 4'b1010; mode=101 on 4'b1000 → 4'b0100; mode=110 → po unchanged.
- Burst: pi=4'b0011, sin_l=0, start pulse → busy=1, sout_r sequence 1,1,0,0 over the next 4 cycles; done=1 for exactly one cycle on the 5th edge with busy=0; final po=4'b0000. A second start during busy is ignored.
- Stall: during burst of pi=4'b1010, drop en for 3 cycles after the 2nd bit → sout_r holds, counter holds; resuming completes the sequence 0,1,0,1 and done arrives 3 cycles late.
- Reset mid-burst: assert rst=0 between clk edges after 2 bits → po=0, busy=0 immediately; no done pulse ever appears; a fresh start afterwards runs normally.

Source files
------------

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised universal shift register with a burst serialiser.
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   en         clock enable for register, counter and FSM updates
//   mode       0 hold, 1 load, 2 shl, 3 shr, 4 rotl, 5 rotr, 6/7 hold
//   pi         parallel data in
//   sin_l      serial in at MSB (shift right and burst fill)
//   sin_r      serial in at LSB (shift left)
//   start      burst request pulse, sampled only in IDLE
//   po         register contents
//   sout_l     po[WIDTH-1], combinational
//   sout_r     po[0], combinational
//   busy       burst in progress
//   done       one-cycle pulse at burst completion
module univ_shift_reg #(
  parameter int unsigned           WIDTH     = 4,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] pi,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  output logic [WIDTH-1:0] po,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      po_q    <= RESET_VAL;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      po_q    <= po_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, datapath and counter logic
  always_comb begin
    state_d = state_q;
    po_d    = po_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            po_d    = pi;
            cnt_d   = CW'(WIDTH);
            busy_d  = 1'b1;
            state_d = BURST;
          end else begin
            case (mode)
              3'b001:  po_d = pi;
              3'b010:  po_d = {po_q[WIDTH-2:0], sin_r};
              3'b011:  po_d = {sin_l, po_q[WIDTH-1:1]};
              3'b100:  po_d = {po_q[WIDTH-2:0], po_q[WIDTH-1]};
              3'b101:  po_d = {po_q[0], po_q[WIDTH-1:1]};
              default: po_d = po_q;
            endcase
          end
        end
        BURST: begin
          po_d = {sin_l, po_q[WIDTH-1:1]};
          if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
          // Last bit leaves on the 1->0 step; a zero count is also treated as final.
          if (cnt_q <= CW'(1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign po     = po_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign sout_l = po_q[WIDTH-1];
  assign sout_r = po_q[0];

endmodule
